// File: rtl/md_defs.sv
// md_defs: shared op codes, FSM states and default width for the multiply/divide unit
package md_defs;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;
endpackage

// File: rtl/md_iter_step.sv
// md_iter_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] nxt,
  output logic               qbit
);
  logic [WIDTH:0] sum, shl, diff;
  // divide packs {remainder, dividend/quotient}; the quotient bit fills the vacated lsb
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & operand};
    shl  = acc[2*WIDTH-1:WIDTH-1];
    diff = shl - {1'b0, operand};
    qbit = div & ~diff[WIDTH];
    nxt  = div ? {qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
               : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide with HI/LO result registers
module mult_div_unit
  import md_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e state, state_d;
  logic [CW-1:0] count;
  logic is_div, neg_p, neg_r, step_q, accept, dz, sa, sb;
  logic [WIDTH-1:0] m, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, step_acc, res;
  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .div(is_div), .acc(acc), .operand(m), .nxt(step_acc), .qbit(step_q)
  );
  assign busy = state != IDLE;
  always_comb begin
    accept  = state == IDLE && start && !op[2];
    dz      = op[1] && b == '0;
    sa      = !op[0] && a[WIDTH-1];
    sb      = !op[0] && b[WIDTH-1];
    mag_a   = sa ? -a : a;
    mag_b   = sb ? -b : b;
    state_d = state == IDLE ? (accept ? (dz ? FIX : RUN) : IDLE)
            : state == RUN  ? (count == CW'(WIDTH-1) ? FIX : RUN)
            : IDLE;
    // quotient follows the product sign rule; remainder takes the dividend's sign
    res = is_div ? {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                    neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]}
                 : (neg_p ? -acc : acc);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      m        <= '0;
      acc      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_d;
      done  <= state == FIX;
      if (accept) begin
        is_div   <= op[1];
        neg_p    <= sa ^ sb;
        neg_r    <= sa;
        m        <= op[1] ? mag_b : mag_a;
        acc      <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
        count    <= '0;
        div_zero <= dz;
      end
      if (state == IDLE && start && op == MD_MTHI) hi <= a;
      if (state == IDLE && start && op == MD_MTLO) lo <= a;
      if (state == RUN) begin
        acc   <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        count <= count + 1'b1;
      end
      if (state == FIX && !div_zero) {hi, lo} <= res;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus randomized checks against an arithmetic reference model
module tb_mult_div_unit;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [31:0] mhi = '0, mlo = '0;
  int n_chk = 0, n_fail = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      3'd0: begin q = sx * sy; return q; end
      3'd1: begin p = ux * uy; return p; end
      3'd2: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: begin p = ux / uy; q = longint'(ux % uy); return {q[31:0], p[31:0]}; end
    endcase
  endfunction

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    bit zero_div, bok;
    int n;
    zero_div = o[1] && y == 0;
    e = zero_div ? {mhi, mlo} : ref_md(o, x, y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    bok = busy;
    n = 0;
    while (n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done) break;
      if (!busy) bok = 1'b0;
    end
    chk({tag, "_lat"}, n, zero_div ? 1 : 33);
    chk({tag, "_busy_run"}, bok, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_hilo"}, {hi, lo}, e);
    chk({tag, "_dz"}, div_zero, zero_div);
    @(posedge clock); #1;
    chk({tag, "_pulse"}, done, 0);
    {mhi, mlo} = e;
  endtask

  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] x);
    @(negedge clock);
    start = 1'b1; op = o; a = x;
    @(posedge clock); #1;
    start = 1'b0;
    if (o == 3'd4) mhi = x; else mlo = x;
    chk({tag, "_hilo"}, {hi, lo}, {mhi, mlo});
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [2:0] o;
    logic [31:0] x, y, r1, r2;
    logic [63:0] e;
    int n, nd, lat;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    #12 reset_n = 1'b1;
    run("mult", 3'd0, 32'd7, 32'hFFFFFFFD);
    chk("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run("div", 3'd2, 32'hFFFFFFF9, 32'd2);
    chk("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run("divu", 3'd3, 32'd100, 32'd7);
    chk("divu_const", {hi, lo}, 64'h00000002_0000000E);
    run("div0", 3'd2, 32'd5, 32'd0);
    run("mult_after_dz", 3'd0, 32'd3, 32'd4);
    run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_const", {hi, lo}, 64'h00000000_80000000);
    mt("mthi", 3'd4, 32'h1234);
    mt("mtlo", 3'd5, 32'h5678);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) x = x >>> $urandom_range(0, 31);
      run("rnd", o, x, y);
    end
    // second start during RUN must be ignored
    x = 32'd12345; y = 32'hFFFF0001;
    e = ref_md(3'd0, x, y);
    @(negedge clock);
    start = 1'b1; op = 3'd0; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0; nd = 0; lat = 0;
    while (n < 80) begin
      @(posedge clock); #1;
      n++;
      if (n == 4) begin start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd5; end
      if (n == 5) start = 1'b0;
      if (done) begin nd++; lat = n; end
    end
    chk("busy_start_ndone", nd, 1);
    chk("busy_start_lat", lat, 33);
    chk("busy_start_hilo", {hi, lo}, e);
    {mhi, mlo} = e;
    // asynchronous reset mid-operation
    r1 = 32'hA5A5A5A5; r2 = 32'h5A5A5A5A;
    mt("pre_rst_hi", 3'd4, r1);
    mt("pre_rst_lo", 3'd5, r2);
    @(negedge clock);
    start = 1'b1; op = 3'd1; a = 32'hDEADBEEF; b = 32'h1234567;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hilo", {hi, lo}, 64'h0);
    chk("mid_rst_done", done, 0);
    @(negedge clock) reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) nd++;
    end
    chk("post_rst_quiet", nd, 0);
    chk("post_rst_hilo", {hi, lo}, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
